ckong_rom_loader: RTL and testbench

Loader stage between `hps_io` and the `ckong` core. It converts the HPS ROM download stream (`ioctl_*`) into registered, region-decoded ROM write strobes, checks the byte count, and owns the core reset sequencing. The core is held in reset from power-up until a complete, valid image has loaded, and again during every reload. Outputs drive the core's ROM write ports and are ORed into the core reset term at the top level.

---
 rtl/ckong_rom_loader.sv | 109 ++++++++++
 tb/tb_ckong_rom_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ckong_rom_loader.sv
// rtl/ckong_rom_loader.sv - HPS ROM download to ckong ROM write strobes with core reset sequencing
// Holds the core in reset until a complete, in-range image of exactly SND_END bytes has loaded.
module ckong_rom_loader #(
  parameter logic [16:0] CPU_END     = 17'h06000,
  parameter logic [16:0] GFX_END     = 17'h0A000,
  parameter logic [16:0] SND_END     = 17'h0C000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        cpu_rom_we,
  output logic        gfx_rom_we,
  output logic        snd_rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [1:0] {WAIT, LOAD, HOLD, RUN} state_t;

  state_t      state, state_nxt;
  logic        dl_q;
  logic [16:0] cnt;
  logic        ovf;
  logic [7:0]  hold_cnt;

  logic        rise, fall, wr_en, addr_hi, in_cpu, in_gfx, in_snd, in_any, img_ok;
  logic [16:0] a17, off, cnt_base;

  always_comb begin
    rise    = ioctl_download & ~dl_q;
    fall    = ~ioctl_download & dl_q;
    a17     = ioctl_addr[16:0];
    addr_hi = |ioctl_addr[24:17];
    // Decode follows the next-state LOAD condition so the first byte of a download is not lost.
    wr_en   = ioctl_wr & ioctl_download & ((state == LOAD) | rise);
    in_cpu  = wr_en & ~addr_hi & (a17 < CPU_END);
    in_gfx  = wr_en & ~addr_hi & (a17 >= CPU_END) & (a17 < GFX_END);
    in_snd  = wr_en & ~addr_hi & (a17 >= GFX_END) & (a17 < SND_END);
    in_any  = in_cpu | in_gfx | in_snd;
    if (in_gfx)      off = a17 - CPU_END;
    else if (in_snd) off = a17 - GFX_END;
    else             off = a17;
    cnt_base = rise ? 17'd0 : cnt;
    img_ok   = (cnt == SND_END) & ~ovf;

    state_nxt = state;
    if (rise) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (fall) state_nxt = img_ok ? HOLD : WAIT;
        HOLD:    if (hold_cnt == 8'd0) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT;
      dl_q       <= 1'b0;
      cnt        <= 17'd0;
      ovf        <= 1'b0;
      hold_cnt   <= 8'd0;
      cpu_rom_we <= 1'b0;
      gfx_rom_we <= 1'b0;
      snd_rom_we <= 1'b0;
      rom_addr   <= 16'd0;
      rom_data   <= 8'd0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      state      <= state_nxt;
      cpu_rom_we <= in_cpu;
      gfx_rom_we <= in_gfx;
      snd_rom_we <= in_snd;
      core_reset <= (state_nxt != RUN);
      load_done  <= (state_nxt == RUN);

      if (in_any) begin
        rom_addr <= off[15:0];
        rom_data <= ioctl_dout;
        cnt      <= (cnt_base == 17'h1FFFF) ? cnt_base : cnt_base + 17'd1;
      end else if (rise) begin
        cnt <= 17'd0;
      end

      if (wr_en & ~in_any) ovf <= 1'b1;
      else if (rise)       ovf <= 1'b0;

      if (rise)                                  load_err <= 1'b0;
      else if ((state == LOAD) & fall & ~img_ok) load_err <= 1'b1;

      // Counter is loaded on HOLD entry so HOLD spans exactly HOLD_CYCLES cycles.
      if ((state_nxt == HOLD) && (state != HOLD))  hold_cnt <= 8'(HOLD_CYCLES - 1);
      else if ((state == HOLD) && (hold_cnt != 0)) hold_cnt <= hold_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_ckong_rom_loader.sv
// tb/tb_ckong_rom_loader.sv - directed bench for ckong_rom_loader
// Full-size instance covers the real memory map; a scaled instance covers the multi-load scenarios.
module tb_ckong_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl = 1'b0;
  logic        wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  dout = '0;

  logic        b_cpu, b_gfx, b_snd, b_rst, b_done, b_err;
  logic [15:0] b_addr;
  logic [7:0]  b_data;
  logic        s_cpu, s_gfx, s_snd, s_rst, s_done, s_err;
  logic [15:0] s_addr;
  logic [7:0]  s_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ckong_rom_loader dut_b (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .cpu_rom_we(b_cpu), .gfx_rom_we(b_gfx),
    .snd_rom_we(b_snd), .rom_addr(b_addr), .rom_data(b_data), .core_reset(b_rst),
    .load_done(b_done), .load_err(b_err)
  );

  ckong_rom_loader #(
    .CPU_END(17'h00060), .GFX_END(17'h000A0), .SND_END(17'h000C0), .HOLD_CYCLES(4)
  ) dut_s (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .cpu_rom_we(s_cpu), .gfx_rom_we(s_gfx),
    .snd_rom_we(s_snd), .rom_addr(s_addr), .rom_data(s_data), .core_reset(s_rst),
    .load_done(s_done), .load_err(s_err)
  );

  // Reference decode of the full-size map, checked every cycle of the full load.
  logic        mon_en = 1'b0;
  logic        mon_v = 1'b0;
  logic [24:0] mon_a = '0;
  int          mon_err = 0;
  int          n_cpu = 0, n_gfx = 0, n_snd = 0;
  logic        ec, eg, es;
  logic [16:0] eo;
  logic        cap_g_we = 1'b0, cap_s_we = 1'b0;
  logic [15:0] cap_g_addr = '1, cap_s_addr = '1;

  always @(posedge clk) begin
    mon_v <= wr & dl;
    mon_a <= addr;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      ec = mon_v && (mon_a < 25'h06000);
      eg = mon_v && (mon_a >= 25'h06000) && (mon_a < 25'h0A000);
      es = mon_v && (mon_a >= 25'h0A000) && (mon_a < 25'h0C000);
      eo = eg ? mon_a[16:0] - 17'h06000 : es ? mon_a[16:0] - 17'h0A000 : mon_a[16:0];
      if (b_cpu !== ec || b_gfx !== eg || b_snd !== es) mon_err++;
      if ((ec || eg || es) && (b_addr !== eo[15:0] || b_data !== mon_a[7:0])) mon_err++;
      n_cpu += int'(b_cpu);
      n_gfx += int'(b_gfx);
      n_snd += int'(b_snd);
      if (mon_v && mon_a == 25'h06000) begin cap_g_we = b_gfx; cap_g_addr = b_addr; end
      if (mon_v && mon_a == 25'h0A005) begin cap_s_we = b_snd; cap_s_addr = b_addr; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      addr = 25'(a);
      dout = 8'(a);
      wr   = 1'b1;
      tick();
    end
    wr = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_reset", b_rst, 1);
    check("rst_strobes", {b_cpu, b_gfx, b_snd}, 0);
    check("rst_rom_addr", b_addr, 0);
    check("rst_rom_data", b_data, 0);
    check("rst_done_err", {b_done, b_err}, 0);
    reset_n = 1'b1;
    tick();

    // Stray write in WAIT
    addr = 25'h00010; dout = 8'h5A; wr = 1'b1;
    tick();
    wr = 1'b0;
    check("stray_wait_b_strobes", {b_cpu, b_gfx, b_snd}, 0);
    check("stray_wait_b_cnt", dut_b.cnt, 0);
    tick();

    // Full-size load 0x0000..0xBFFF, download rises together with the first write
    mon_en = 1'b1;
    dl = 1'b1;
    stream(0, 32'hBFFF);
    dl = 1'b0;
    tick();
    mon_en = 1'b0;
    check("full_decode_errors", mon_err, 0);
    check("full_cpu_count", n_cpu, 24576);
    check("full_gfx_count", n_gfx, 16384);
    check("full_snd_count", n_snd, 8192);
    check("full_0x6000_gfx", {cap_g_we, cap_g_addr}, {1'b1, 16'h0000});
    check("full_0xA005_snd", {cap_s_we, cap_s_addr}, {1'b1, 16'h0005});
    repeat (15) tick();
    check("hold15_core_reset", {b_rst, b_done}, 2'b10);
    tick();
    check("hold16_core_reset", {b_rst, b_done}, 2'b01);
    check("full_load_err", b_err, 0);

    // Stray write in RUN
    addr = 25'h00020; wr = 1'b1;
    tick();
    wr = 1'b0;
    check("stray_run_b_strobes", {b_cpu, b_gfx, b_snd}, 0);
    check("stray_run_b_cnt", dut_b.cnt, 32'h0C000);
    check("stray_run_b_done", {b_rst, b_done}, 2'b01);
    tick();

    // Scaled instance: short image
    dl = 1'b1;
    stream(0, 32'hBE);
    dl = 1'b0;
    tick();
    tick();
    check("short_err", s_err, 1);
    repeat (20) tick();
    check("short_core_reset_held", {s_rst, s_done}, 2'b10);

    // Stray write in WAIT on the scaled instance
    addr = 25'h00005; wr = 1'b1;
    tick();
    wr = 1'b0;
    check("stray_wait_s_strobes", {s_cpu, s_gfx, s_snd}, 0);
    check("stray_wait_s_cnt", dut_s.cnt, 32'hBF);

    // Out-of-range: full image plus 0xC0 and an address with bit 17 set
    dl = 1'b1;
    stream(0, 32'hBF);
    addr = 25'h000C0; wr = 1'b1;
    tick();
    check("oor_c0_no_strobe", {s_cpu, s_gfx, s_snd}, 0);
    addr = 25'h20005;
    tick();
    check("oor_hi_no_strobe", {s_cpu, s_gfx, s_snd}, 0);
    wr = 1'b0; dl = 1'b0;
    tick();
    repeat (8) tick();
    check("oor_err", s_err, 1);
    check("oor_core_reset", {s_rst, s_done}, 2'b10);

    // Good scaled load with boundary writes checked inline
    dl = 1'b1;
    stream(0, 32'h5F);
    addr = 25'h00060; dout = 8'hC3; wr = 1'b1;
    tick();
    check("s_gfx_base", {s_cpu, s_gfx, s_snd, s_addr, s_data}, {3'b010, 16'h0000, 8'hC3});
    stream(32'h61, 32'h9F);
    check("s_hold_rom_data", {s_addr, s_data}, {16'h003F, 8'h9F});
    addr = 25'h000A0; dout = 8'h3C; wr = 1'b1;
    tick();
    check("s_snd_base", {s_cpu, s_gfx, s_snd, s_addr, s_data}, {3'b001, 16'h0000, 8'h3C});
    stream(32'hA1, 32'hBF);
    dl = 1'b0;
    tick();
    repeat (3) tick();
    check("s_hold3", {s_rst, s_done}, 2'b10);
    tick();
    check("s_run", {s_rst, s_done, s_err}, 3'b010);

    // Reload from RUN
    dl = 1'b1;
    tick();
    check("reload_core_reset", {s_rst, s_done}, 2'b10);
    stream(0, 32'hBF);
    dl = 1'b0;
    tick();
    repeat (4) tick();
    check("reload_run", {s_rst, s_done, s_err}, 3'b010);

    // Reset mid-load
    dl = 1'b1;
    stream(0, 32'h2F);
    addr = 25'h00030; wr = 1'b1;
    reset_n = 1'b0;
    #1;
    check("midrst_s_outputs", {s_cpu, s_gfx, s_snd, s_addr, s_data, s_rst, s_done, s_err},
          {3'b000, 16'h0000, 8'h00, 3'b100});
    check("midrst_s_cnt", dut_s.cnt, 0);
    wr = 1'b0;
    tick();
    reset_n = 1'b1;
    stream(32'h30, 32'hBF);
    dl = 1'b0;
    tick();
    repeat (8) tick();
    check("midrst_stays_wait", {s_rst, s_done}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
